// File: rtl/contador_modular.sv
// contador_modular: synchronous up/down counter with a configurable modulus,
// wrap-or-saturate behaviour at the range limits, and event reporting.
//
// Parameters:
//   WIDTH    - counter width in bits (1..32)
//   MODULO   - count range 0..MODULO-1 (2..2**WIDTH)
//   SATURATE - 0: wrap around at the limits, 1: hold at the limits
//
// Ports:
//   clk      - clock, all state changes on the rising edge
//   reset    - asynchronous active-low reset
//   clr      - synchronous clear (highest priority)
//   load     - synchronous parallel load of load_val (clamped to MODULO-1)
//   load_val - value to load
//   en       - count enable
//   up       - direction: 1 = increment, 0 = decrement
//   count    - registered current count
//   tc       - terminal count for the current direction (combinational)
//   wrap     - registered one-cycle pulse on a wrap/saturation event
//   ovf      - sticky flag, set by any wrap/saturation event
module contador_modular #(
  parameter int unsigned     WIDTH    = 4,
  parameter longint unsigned MODULO   = 16,
  parameter bit              SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             ovf
);

  // MODULO may equal 2**WIDTH, so the bound is kept one bit wider than count.
  localparam logic [WIDTH-1:0] TOP  = WIDTH'(MODULO - 1);
  localparam logic [WIDTH:0]   MODV = (WIDTH + 1)'(MODULO);

  logic at_top;
  logic at_bottom;

  assign at_top    = (count == TOP);
  assign at_bottom = (count == '0);
  assign tc        = up ? at_top : at_bottom;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
      wrap  <= 1'b0;
      ovf   <= 1'b0;
    end else if (clr) begin
      count <= '0;
      wrap  <= 1'b0;
      ovf   <= 1'b0;
    end else if (load) begin
      count <= ({1'b0, load_val} < MODV) ? load_val : TOP;
      wrap  <= 1'b0;
    end else if (en) begin
      if (up) begin
        if (at_top) begin
          count <= SATURATE ? TOP : '0;
          wrap  <= 1'b1;
          ovf   <= 1'b1;
        end else begin
          count <= count + WIDTH'(1);
          wrap  <= 1'b0;
        end
      end else begin
        if (at_bottom) begin
          count <= SATURATE ? '0 : TOP;
          wrap  <= 1'b1;
          ovf   <= 1'b1;
        end else begin
          count <= count - WIDTH'(1);
          wrap  <= 1'b0;
        end
      end
    end else begin
      wrap <= 1'b0;
    end
  end

endmodule

// File: doc/contador_modular.md
CONTADOR_MODULAR -- requirements
Module: contador_modular

Interface
REQ-001 Parameter WIDTH, default 4: counter width in bits; legal range 1..32.
REQ-002 Parameter MODULO, default 16: count range 0..MODULO-1; legal range 2..2**WIDTH.
REQ-003 Parameter SATURATE, default 0: 0 = wrap at the range limits, 1 = hold at the range limits.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset; asserted when 0, takes effect immediately, independent of clk.
REQ-006 clr  input  1  synchronous clear, active-high.
REQ-007 load  input  1  synchronous parallel load, active-high.
REQ-008 load_val  input  WIDTH  value loaded when load=1.
REQ-009 en  input  1  count enable, active-high.
REQ-010 up  input  1  direction: 1 = increment, 0 = decrement.
REQ-011 count  output  WIDTH  registered current count.
REQ-012 tc  output  1  terminal count: count is at the limit for the current direction.
REQ-013 wrap  output  1  registered one-cycle pulse marking a wrap or saturation event.
REQ-014 ovf  output  1  sticky flag: at least one wrap or saturation event has occurred.

Function
REQ-015 Per-edge priority SHALL be clr > load > en; with none asserted, count, wrap=0 and ovf SHALL hold.
REQ-016 clr=1: count<=0, wrap<=0, ovf<=0.
REQ-017 load=1 (clr=0): count<=load_val if load_val<MODULO, else count<=MODULO-1; wrap<=0; ovf unchanged.
REQ-018 en=1, up=1, count<MODULO-1: count<=count+1; wrap<=0.
REQ-019 en=1, up=0, count>0: count<=count-1; wrap<=0.
REQ-020 en=1, up=1, count=MODULO-1: SATURATE=0 gives count<=0; SATURATE=1 gives count holds at MODULO-1; in both cases wrap<=1 and ovf<=1.
REQ-021 en=1, up=0, count=0: SATURATE=0 gives count<=MODULO-1; SATURATE=1 gives count holds at 0; in both cases wrap<=1 and ovf<=1.
REQ-022 wrap SHALL be high for exactly one cycle per event; consecutive saturation edges with en=1 SHALL keep wrap high on each such cycle.
REQ-023 tc SHALL be combinational from count and up: tc = (up=1 AND count=MODULO-1) OR (up=0 AND count=0); tc SHALL be independent of en.
REQ-024 A change of up mid-count SHALL take effect on the next enabled edge with no lost or duplicated step.
REQ-025 Arithmetic SHALL be modulo MODULO, not 2**WIDTH; count SHALL never exceed MODULO-1.
REQ-026 All flops SHALL share one clock domain (fully synchronous counter, no derived or rippled clocks).
REQ-027 When MODULO=2**WIDTH, behaviour SHALL equal natural binary rollover.

Reset
REQ-028 While reset=0: count=0, wrap=0, ovf=0, regardless of clk and all other inputs.
REQ-029 Reset assertion mid-count SHALL clear state immediately, without waiting for a clock edge.
REQ-030 After reset returns to 1, the first rising edge SHALL be processed normally per REQ-015.

Verification (WIDTH=4, MODULO=10 unless stated)
REQ-031 Reset, then en=1, up=1, SATURATE=0 for 12 edges -> count goes 1..9, 0, 1, 2; wrap pulses on the edge producing 0; ovf=1 from that edge; tc=1 while count=9.
REQ-032 SATURATE=1, load_val=8 loaded, then en=1, up=1 for 3 edges -> count 9, 9, 9; wrap=1 on the 2nd and 3rd edges; ovf=1.
REQ-033 Count=0, up=0, en=1, SATURATE=0 -> count=9, wrap pulse, tc=0 after the edge; with up=0, tc=0 at count=9.
REQ-034 load=1, load_val=13 -> count=9; same edge with clr=1 -> count=0 and ovf=0 (clr wins).
REQ-035 Count=5, ovf=1; pull reset=0 between edges -> count, wrap and ovf read 0 before the next clk edge; hold reset=0 across edges with en=1 -> values stay 0.
REQ-036 WIDTH=8, MODULO=256, SATURATE=0, count=255, up=1, en=1 -> count=0, wrap=1; en=0 for 2 edges -> count holds at 0, wrap=0.
